// File: rtl/score_bcd_display.sv
// Score readout: 8-bit binary score -> three BCD digits (sequential double-dabble) -> 4-digit muxed 7-seg.
// Optional leading-zero blanking when SCORE_LZB_EN is defined.
module score_bcd_display #(
    parameter int SCAN_DIV = 16
) (
    input  logic       C,
    input  logic       INIT_N,
    input  logic [7:0] SCORE,
    input  logic       LOAD,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] HUND,
    output logic [3:0] TENS,
    output logic [3:0] ONES,
    output logic [3:0] AN,
    output logic [6:0] SEG
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [19:0]      work_q, work_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0]       hund_q, hund_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       dig_q, dig_d;

    logic [19:0]      work_adj;
    logic [19:0]      work_sh;
    logic [3:0]       sel_digit;
    logic             blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // The work MSB is always 0 for an 8-bit input, so rotating is identical to shifting in a 0.
    assign work_adj = {add3(work_q[19:16]), add3(work_q[15:12]), add3(work_q[11:8]), work_q[7:0]};
    assign work_sh  = {work_adj[18:0], work_adj[19]};

    always_ff @(posedge C or negedge INIT_N) begin
        if (!INIT_N) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (LOAD) begin
                    work_d  = {12'd0, SCORE};
                    cnt_d   = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = work_sh;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    hund_d  = work_sh[19:16];
                    tens_d  = work_sh[15:12];
                    ones_d  = work_sh[11:8];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state_q == SHIFT);
        DONE = done_q;
    end

    always_ff @(posedge C or negedge INIT_N) begin
        if (!INIT_N) begin
            work_q <= '0;
            cnt_q  <= '0;
            hund_q <= '0;
            tens_q <= '0;
            ones_q <= '0;
            done_q <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            hund_q <= hund_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
            done_q <= done_d;
        end
    end

    assign HUND = hund_q;
    assign TENS = tens_q;
    assign ONES = ones_q;

    // Display scan runs continuously, independent of the conversion engine.
    always_comb begin
        div_d = div_q + 1'b1;
        dig_d = dig_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
        end
    end

    always_ff @(posedge C or negedge INIT_N) begin
        if (!INIT_N) begin
            div_q <= '0;
            dig_q <= '0;
        end else begin
            div_q <= div_d;
            dig_q <= dig_d;
        end
    end

    always_comb begin
        sel_digit = ones_q;
        blank     = 1'b0;
        case (dig_q)
            2'd1:    sel_digit = tens_q;
            2'd2:    sel_digit = hund_q;
            default: sel_digit = ones_q;
        endcase
`ifdef SCORE_LZB_EN
        if (dig_q == 2'd2 && hund_q == 4'd0)                     blank = 1'b1;
        if (dig_q == 2'd1 && hund_q == 4'd0 && tens_q == 4'd0)   blank = 1'b1;
`endif
        AN  = ~(4'b0001 << dig_q);
        SEG = blank ? 7'b1111111 : seg_decode(sel_digit);
    end

endmodule

// File: tb/tb_score_bcd_display.sv
// Scoreboard bench for score_bcd_display: stimulus pushes expected results, a monitor checks
// conversions, BUSY timing and the display scan every cycle.
module tb_score_bcd_display;
    localparam int DIV = 4;

    logic       C = 1'b0;
    logic       INIT_N = 1'b0;
    logic       LOAD = 1'b0;
    logic [7:0] SCORE = 8'd0;
    logic       BUSY, DONE;
    logic [3:0] HUND, TENS, ONES, AN;
    logic [6:0] SEG;

    always #5 C = ~C;

    score_bcd_display #(.SCAN_DIV(DIV)) dut (
        .C(C), .INIT_N(INIT_N), .SCORE(SCORE), .LOAD(LOAD),
        .BUSY(BUSY), .DONE(DONE), .HUND(HUND), .TENS(TENS), .ONES(ONES),
        .AN(AN), .SEG(SEG)
    );

    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        int         ecyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   m = 0;
    int   total = 0;
    int   bad = 0;
    logic [3:0] disp_h = 4'd0, disp_t = 4'd0, disp_o = 4'd0;

    always @(posedge C) cyc++;

    // Edges since reset release: the scan position follows from this alone.
    always @(posedge C or negedge INIT_N) begin
        if (!INIT_N) m = 0;
        else         m++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int dig);
        if (dig == 0) return seg7(disp_o);
        if (dig == 1) begin
`ifdef SCORE_LZB_EN
            if (disp_h == 4'd0 && disp_t == 4'd0) return 7'b1111111;
`endif
            return seg7(disp_t);
        end
`ifdef SCORE_LZB_EN
        if (disp_h == 4'd0) return 7'b1111111;
`endif
        return seg7(disp_h);
    endfunction

    // Monitor
    initial begin
        exp_t       e;
        logic       exp_busy;
        int         dig;
        logic [3:0] exp_an;
        forever begin
            @(posedge C);
            #1;
            if (!INIT_N) begin
                disp_h = 4'd0; disp_t = 4'd0; disp_o = 4'd0;
                chk("rst_busy", BUSY, 0);
                chk("rst_done", DONE, 0);
                chk("rst_hund", HUND, 0);
                chk("rst_tens", TENS, 0);
                chk("rst_ones", ONES, 0);
            end else begin
                if (DONE) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_done at cycle %0d: got=1 want=0", cyc);
                    end else begin
                        e = q.pop_front();
                        chk("done_cycle", cyc, e.ecyc);
                        chk("hund", HUND, e.h);
                        chk("tens", TENS, e.t);
                        chk("ones", ONES, e.o);
                        disp_h = e.h; disp_t = e.t; disp_o = e.o;
                    end
                end
                if (q.size() > 0 && cyc > q[0].ecyc) begin
                    total++;
                    bad++;
                    $display("FAIL done_missing at cycle %0d: got=none want=cycle %0d", cyc, q[0].ecyc);
                    void'(q.pop_front());
                end
                exp_busy = (q.size() > 0) && (cyc >= q[0].ecyc - 8) && (cyc < q[0].ecyc);
                chk("busy", BUSY, exp_busy);
            end
            dig    = (m / DIV) % 3;
            exp_an = ~(4'b0001 << dig);
            chk("an", AN, exp_an);
            chk("seg", SEG, exp_seg(dig));
        end
    end

    task automatic do_load(input logic [7:0] s, input bit accept,
                           input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        exp_t e;
        @(negedge C);
        SCORE = s;
        LOAD  = 1'b1;
        if (accept) begin
            e.h = h; e.t = t; e.o = o; e.ecyc = cyc + 9;
            q.push_back(e);
        end
        @(negedge C);
        LOAD = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge C);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout at cycle %0d: got=%0d pending want=0", cyc, q.size());
            q.delete();
        end
        repeat (2) @(negedge C);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge C);
        INIT_N = 1'b1;

        // Full-scale conversion, then watch the scan for more than one full cycle.
        do_load(8'd255, 1, 4'd2, 4'd5, 4'd5);
        drain();
        repeat (14) @(negedge C);

        do_load(8'd1,   1, 4'd0, 4'd0, 4'd1); drain();
        do_load(8'd100, 1, 4'd1, 4'd0, 4'd0); drain();
        do_load(8'd0,   1, 4'd0, 4'd0, 4'd0); drain();

        // Load while busy is ignored.
        do_load(8'd128, 1, 4'd1, 4'd2, 4'd8);
        repeat (2) @(negedge C);
        do_load(8'd7, 0, 4'd0, 4'd0, 4'd0);
        drain();

        // LOAD held high through the DONE cycle starts a second conversion right away.
        @(negedge C);
        SCORE = 8'd99;
        LOAD  = 1'b1;
        e.h = 4'd0; e.t = 4'd9; e.o = 4'd9; e.ecyc = cyc + 9;
        q.push_back(e);
        repeat (9) @(negedge C);
        SCORE = 8'd200;
        e.h = 4'd2; e.t = 4'd0; e.o = 4'd0; e.ecyc = cyc + 9;
        q.push_back(e);
        @(negedge C);
        LOAD = 1'b0;
        drain();

        // Abort mid-conversion with a 3-cycle reset.
        do_load(8'd77, 1, 4'd0, 4'd7, 4'd7);
        repeat (3) @(negedge C);
        INIT_N = 1'b0;
        q.delete();
        repeat (3) @(negedge C);
        INIT_N = 1'b1;
        repeat (12) @(negedge C);
        do_load(8'd42, 1, 4'd0, 4'd4, 4'd2);
        drain();

        // Small value exercises leading-zero handling on the display.
        do_load(8'd5, 1, 4'd0, 4'd0, 4'd5);
        drain();
        repeat (14) @(negedge C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
